// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation encoding and FSM state codes.
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } hilo_op_t;

  typedef logic [1:0] hilo_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic op_is_signed_mul(input hilo_op_t op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_acc(input hilo_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/hilo_mul.sv
// Combinational 33x33 multiply with optional accumulate/subtract onto a 64-bit HI:LO value.
module hilo_mul #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  input  logic           acc_en,
  input  logic           acc_sub,
  input  logic [2*W-1:0] acc_in,
  output logic [2*W-1:0] result
);

  // The extra top bit turns both signed and unsigned operands into one signed multiply.
  logic [W:0] a_x;
  logic [W:0] b_x;
  logic signed [2*W-1:0] a_w;
  logic signed [2*W-1:0] b_w;
  logic signed [2*W-1:0] prod;

  assign a_x  = {is_signed & a[W-1], a};
  assign b_x  = {is_signed & b[W-1], b};
  assign a_w  = {{(W-1){a_x[W]}}, a_x};
  assign b_w  = {{(W-1){b_x[W]}}, b_x};
  assign prod = a_w * b_w;

  always_comb begin
    result = prod;
    if (acc_en) begin
      if (acc_sub) result = acc_in - prod;
      else         result = acc_in + prod;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Execute-stage HI/LO unit: single-cycle multiplies, divider sequencing with pipeline stall, MT/MF moves.
// Define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise those encodings behave as no-ops.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int              DATA_W = 32,
  parameter logic [DATA_W-1:0] HI_RST = '0,
  parameter logic [DATA_W-1:0] LO_RST = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  hilo_op_t              ex_op,
  input  logic [DATA_W-1:0]     ex_rs,
  input  logic [DATA_W-1:0]     ex_rt,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic [DATA_W-1:0]     mf_data,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  div_op,
  output logic                  div_signed,
  output logic [DATA_W-1:0]     div_dividend,
  output logic [DATA_W-1:0]     div_divisor,
  input  logic [2*DATA_W-1:0]   div_result,
  input  logic                  div_done,
  output hilo_state_t           state_dbg
);

  // Handshake: div_op is a one-cycle launch, only ever raised while div_done is high (divider idle);
  // the divider drops div_done during ISSUE and raises it again with div_result valid when finished.

  hilo_state_t            state;
  hilo_state_t            state_nxt;
  hilo_op_t               op;
  logic [DATA_W-1:0]      hi_q;
  logic [DATA_W-1:0]      lo_q;
  logic                   stall_c;
  logic                   div_launch;
  logic                   div_we;
  logic                   is_div;
  logic                   idle_acc;
  logic                   mul_we;
  logic [2*DATA_W-1:0]    mul_res;

  // Decoded op: invalid slots, unknown codes and (when disabled) accumulate ops become NONE.
  always_comb begin
    op = OP_NONE;
    if (ex_valid) begin
      case (ex_op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: op = ex_op;
`ifdef HILO_MADD_EN
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op = ex_op;
`endif
        default: op = OP_NONE;
      endcase
    end
  end

  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign idle_acc = (state == ST_IDLE) && !ex_flush;
  assign mul_we   = idle_acc && ((op == OP_MULT) || (op == OP_MULTU) || op_is_acc(op));

  always_comb begin
    state_nxt  = state;
    stall_c    = 1'b0;
    div_launch = 1'b0;
    div_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_div && !ex_flush) begin
          stall_c = 1'b1;
          if (div_done) begin
            div_launch = 1'b1;
            state_nxt  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // div_done may still be stale here, so it is not looked at.
        stall_c   = 1'b1;
        state_nxt = ex_flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (ex_flush) begin
          stall_c   = !div_done;
          state_nxt = ST_DRAIN;
        end else if (div_done) begin
          div_we    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        stall_c = (op != OP_NONE);
        if (div_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  hilo_mul #(.W(DATA_W)) u_mul (
    .a         (ex_rs),
    .b         (ex_rt),
    .is_signed (op_is_signed_mul(op)),
    .acc_en    (op_is_acc(op)),
    .acc_sub   ((op == OP_MSUB) || (op == OP_MSUBU)),
    .acc_in    ({hi_q, lo_q}),
    .result    (mul_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hi_q  <= HI_RST;
      lo_q  <= LO_RST;
    end else begin
      state <= state_nxt;
      if (div_we) begin
        lo_q <= div_result[2*DATA_W-1:DATA_W];
        hi_q <= div_result[DATA_W-1:0];
      end else if (mul_we) begin
        {hi_q, lo_q} <= mul_res;
      end else if (idle_acc && (op == OP_MTHI)) begin
        hi_q <= ex_rs;
      end else if (idle_acc && (op == OP_MTLO)) begin
        lo_q <= ex_rs;
      end
    end
  end

  assign stall        = stall_c && !rst;
  assign div_op       = div_launch && !rst;
  assign div_signed   = (ex_op == OP_DIV);
  assign div_dividend = ex_rs;
  assign div_divisor  = ex_rt;
  assign mf_data      = (ex_op == OP_MFHI) ? hi_q : lo_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl; the bench itself plays the divider on the div_op/div_done handshake.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  hilo_op_t    ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_flush;
  logic        stall;
  logic [31:0] mf_data;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_op;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [63:0] div_result;
  logic        div_done;
  hilo_state_t state_dbg;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .mf_data      (mf_data),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .div_op       (div_op),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_result   (div_result),
    .div_done     (div_done),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    exp_q.push_back({m_hi, m_lo});
  endtask

  task automatic chk_hilo(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk64(tag, {hi_o, lo_o}, e);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input hilo_op_t op, input logic [31:0] rs, input logic [31:0] rt);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_rs    = rs;
    ex_rt    = rt;
    ex_flush = 1'b0;
  endtask

  task automatic drv_idle();
    ex_valid = 1'b0;
    ex_op    = OP_NONE;
    ex_rs    = $urandom;
    ex_rt    = $urandom;
    ex_flush = 1'b0;
  endtask

  // Full divide: launch in IDLE, ISSUE, lat busy cycles in WAIT, done cycle, then HI/LO check.
  task automatic run_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] q, input logic [31:0] r, input int lat);
    next();
    drv(sgn ? OP_DIV : OP_DIVU, rs, rt);
    m_lo = q;
    m_hi = r;
    push_model();
    @(negedge clk);
    chk1("div_launch", div_op, 1'b1);
    chk1("div_signed", div_signed, sgn);
    chk32("div_dividend", div_dividend, rs);
    chk32("div_divisor", div_divisor, rt);
    chk1("div_launch_stall", stall, 1'b1);
    next();
    div_done = 1'b0;
    @(negedge clk);
    chk1("issue_stall", stall, 1'b1);
    chk1("issue_no_relaunch", div_op, 1'b0);
    for (int i = 0; i < lat; i++) begin
      next();
      @(negedge clk);
      chk1("wait_stall", stall, 1'b1);
    end
    next();
    div_done   = 1'b1;
    div_result = {q, r};
    @(negedge clk);
    chk1("done_stall_drop", stall, 1'b0);
    chk1("done_no_launch", div_op, 1'b0);
    next();
    drv_idle();
    div_result = {$urandom, $urandom};
    @(negedge clk);
    chk_hilo("div_hilo");
    chk32("div_back_idle", {30'b0, state_dbg}, {30'b0, ST_IDLE});
  endtask

  task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    next();
    drv(sgn ? OP_MULT : OP_MULTU, a, b);
    {m_hi, m_lo} = ax * bx;
    push_model();
    @(negedge clk);
    chk1("mul_no_stall", stall, 1'b0);
    next();
    drv_idle();
    @(negedge clk);
    chk_hilo("mul_hilo");
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;

    // Reset: a DIV presented during reset must neither stall nor launch.
    rst        = 1'b1;
    div_done   = 1'b1;
    div_result = '0;
    drv(OP_DIV, 32'd10, 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_div_op", div_op, 1'b0);
    next();
    rst = 1'b0;
    drv_idle();
    m_hi = 32'h0;
    m_lo = 32'h0;
    push_model();
    @(negedge clk);
    chk_hilo("rst_hilo");
    chk32("rst_state", {30'b0, state_dbg}, {30'b0, ST_IDLE});

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 3);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1);
    for (int k = 0; k < 2; k++) begin
      a = $urandom;
      b = $urandom_range(1, 1000);
      run_div(1'b0, a, b, a / b, a % b, $urandom_range(0, 4));
    end

    // MULTU, MULT back-to-back, then MFLO/MFHI without stalls.
    next();
    drv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    m_hi = 32'hFFFF_FFFE;
    m_lo = 32'h0000_0001;
    push_model();
    @(negedge clk);
    chk1("multu_no_stall", stall, 1'b0);
    next();
    drv(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFA;
    push_model();
    @(negedge clk);
    chk_hilo("multu_hilo");
    chk1("mult_no_stall", stall, 1'b0);
    next();
    drv(OP_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    chk_hilo("mult_hilo");
    chk32("mflo_data", mf_data, 32'hFFFF_FFFA);
    chk1("mflo_no_stall", stall, 1'b0);
    next();
    drv(OP_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    chk32("mfhi_data", mf_data, 32'hFFFF_FFFF);

    for (int k = 0; k < 4; k++) run_mul(k[0], $urandom, $urandom);

    // MTHI then MFHI; LO must be untouched. Then MTLO/MFLO.
    next();
    drv(OP_MTHI, 32'h0000_1234, 32'h0);
    m_hi = 32'h0000_1234;
    push_model();
    @(negedge clk);
    next();
    drv(OP_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    chk32("mthi_mfhi", mf_data, 32'h0000_1234);
    chk_hilo("mthi_hilo");
    next();
    drv(OP_MTLO, 32'hABCD_0042, 32'h0);
    m_lo = 32'hABCD_0042;
    push_model();
    @(negedge clk);
    next();
    drv(OP_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    chk32("mtlo_mflo", mf_data, 32'hABCD_0042);
    chk_hilo("mtlo_hilo");

    // Flushed MULT leaves HI/LO alone.
    next();
    drv(OP_MULT, 32'd7, 32'd9);
    ex_flush = 1'b1;
    @(negedge clk);
    next();
    drv_idle();
    push_model();
    @(negedge clk);
    chk_hilo("flushed_mult");

    // DIV flushed in WAIT: MFHI stalls through DRAIN, then reads the old HI.
    next();
    drv(OP_DIV, 32'd50, 32'd5);
    @(negedge clk);
    chk1("fl_launch", div_op, 1'b1);
    next();
    div_done = 1'b0;
    @(negedge clk);
    chk1("fl_issue_stall", stall, 1'b1);
    next();
    ex_flush = 1'b1;
    @(negedge clk);
    chk32("fl_in_wait", {30'b0, state_dbg}, {30'b0, ST_WAIT});
    next();
    drv(OP_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    chk32("fl_in_drain", {30'b0, state_dbg}, {30'b0, ST_DRAIN});
    chk1("fl_drain_stall", stall, 1'b1);
    next();
    @(negedge clk);
    chk1("fl_drain_stall2", stall, 1'b1);
    next();
    div_done   = 1'b1;
    div_result = {32'd10, 32'd0};
    @(negedge clk);
    chk1("fl_drain_done_stall", stall, 1'b1);
    chk1("fl_drain_no_launch", div_op, 1'b0);
    next();
    @(negedge clk);
    chk1("fl_idle_no_stall", stall, 1'b0);
    chk32("fl_mfhi_old", mf_data, m_hi);
    push_model();
    chk_hilo("fl_hilo");

`ifdef HILO_MADD_EN
    next();
    drv(OP_MTHI, 32'd0, 32'd0);
    @(negedge clk);
    next();
    drv(OP_MTLO, 32'd5, 32'd0);
    @(negedge clk);
    next();
    drv(OP_MADD, 32'd2, 32'd3);
    m_hi = 32'd0;
    m_lo = 32'd11;
    push_model();
    @(negedge clk);
    chk1("madd_no_stall", stall, 1'b0);
    next();
    drv(OP_MSUBU, 32'd1, 32'd12);
    @(negedge clk);
    chk_hilo("madd_hilo");
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFF;
    push_model();
    next();
    drv_idle();
    @(negedge clk);
    chk_hilo("msubu_hilo");
`else
    next();
    drv(OP_MADD, 32'd2, 32'd3);
    push_model();
    @(negedge clk);
    chk1("madd_off_no_stall", stall, 1'b0);
    next();
    drv(OP_MSUBU, 32'd1, 32'd12);
    @(negedge clk);
    chk_hilo("madd_off_hilo");
    push_model();
    next();
    drv_idle();
    @(negedge clk);
    chk_hilo("msubu_off_hilo");
`endif

    // Reset in the middle of a divide returns to IDLE with reset HI/LO.
    next();
    drv(OP_DIVU, 32'd9, 32'd3);
    @(negedge clk);
    next();
    div_done = 1'b0;
    next();
    rst = 1'b1;
    @(negedge clk);
    chk1("rst_mid_stall", stall, 1'b0);
    next();
    rst      = 1'b0;
    div_done = 1'b1;
    drv_idle();
    m_hi = 32'h0;
    m_lo = 32'h0;
    push_model();
    @(negedge clk);
    chk32("rst_mid_state", {30'b0, state_dbg}, {30'b0, ST_IDLE});
    chk_hilo("rst_mid_hilo");

    next();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
